// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead group per stage,
// group carry registered between stages, global stall driven by output backpressure.
module pipelined_cla_addsub #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             carryin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int NGRP = WIDTH / BLOCK;

  if ((WIDTH % BLOCK) != 0) begin : g_width_check
    $error("pipelined_cla_addsub: WIDTH must be a multiple of BLOCK");
  end

  // Returns {carry out, carry into group MSB, sum bits} using flattened lookahead carries.
  function automatic logic [BLOCK+1:0] cla_group(
    input logic [BLOCK-1:0] a,
    input logic [BLOCK-1:0] b,
    input logic             cin
  );
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;
    logic             pp;
    g    = a & b;
    p    = a ^ b;
    c    = {(BLOCK+1){1'b0}};
    c[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      c[i+1] = g[i];
      pp     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & cin);
    end
    return {c[BLOCK], c[BLOCK-1], p ^ c[BLOCK-1:0]};
  endfunction

  // Drops a group's sum bits into its slot of the travelling result word.
  function automatic logic [WIDTH-1:0] insert_group(
    input logic [WIDTH-1:0] y,
    input logic [BLOCK-1:0] bits,
    input int               k
  );
    logic [WIDTH-1:0] r;
    r = y;
    r[k*BLOCK +: BLOCK] = bits;
    return r;
  endfunction

  logic             stall_s;
  logic [NGRP:0]    v_r;
  logic [NGRP-1:0]  c_r;
  logic [WIDTH-1:0] a_r    [NGRP];
  logic [WIDTH-1:0] b_r    [NGRP];
  logic [WIDTH-1:0] y_r    [NGRP];
  logic [WIDTH-1:0] y_nx_s [NGRP];
  logic [BLOCK+1:0] res_s  [NGRP];
  logic [WIDTH-1:0] y_out_r;
  logic             cout_r;
  logic             ovf_r;
  logic             zero_r;

  assign stall_s   = v_r[NGRP] & ~out_ready;
  assign in_ready  = ~stall_s;
  assign out_valid = v_r[NGRP];
  assign Y         = y_out_r;
  assign carryout  = cout_r;
  assign overflow  = ovf_r;
  assign zero      = zero_r;

  for (genvar k = 0; k < NGRP; k++) begin : g_grp
    assign res_s[k]  = cla_group(a_r[k][k*BLOCK +: BLOCK], b_r[k][k*BLOCK +: BLOCK], c_r[k]);
    assign y_nx_s[k] = insert_group(y_r[k], res_s[k][BLOCK-1:0], k);
  end

  // Pipeline ranks: rank 0 captures effective operands, each later rank holds one more resolved group.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_r     <= {(NGRP+1){1'b0}};
      c_r     <= {NGRP{1'b0}};
      y_out_r <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      zero_r  <= 1'b0;
      for (int k = 0; k < NGRP; k++) begin
        a_r[k] <= {WIDTH{1'b0}};
        b_r[k] <= {WIDTH{1'b0}};
        y_r[k] <= {WIDTH{1'b0}};
      end
    end else if (!stall_s) begin
      v_r[0] <= in_valid;
      a_r[0] <= A;
      b_r[0] <= sub ? ~B : B;
      c_r[0] <= carryin ^ sub;
      y_r[0] <= {WIDTH{1'b0}};
      for (int k = 1; k < NGRP; k++) begin
        v_r[k] <= v_r[k-1];
        a_r[k] <= a_r[k-1];
        b_r[k] <= b_r[k-1];
        c_r[k] <= res_s[k-1][BLOCK+1];
        y_r[k] <= y_nx_s[k-1];
      end
      v_r[NGRP] <= v_r[NGRP-1];
      // Bubbles leave the visible result and flags untouched.
      if (v_r[NGRP-1]) begin
        y_out_r <= y_nx_s[NGRP-1];
        cout_r  <= res_s[NGRP-1][BLOCK+1];
        ovf_r   <= res_s[NGRP-1][BLOCK+1] ^ res_s[NGRP-1][BLOCK];
        zero_r  <= (y_nx_s[NGRP-1] == {WIDTH{1'b0}});
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Self-checking bench for pipelined_cla_addsub (WIDTH=16, BLOCK=4): arithmetic reference
// queue checked every output cycle, plus directed vectors with literal expectations.
module tb_pipelined_cla_addsub;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = 16'h0000;
  logic [W-1:0] B = 16'h0000;
  logic         carryin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] Y;
  logic         carryout;
  logic         overflow;
  logic         zero;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int acc_cnt  = 0;
  int dlv_cnt  = 0;
  int drop_cnt = 0;
  logic [18:0] exp_q [$];

  always #5 clk = ~clk;

  pipelined_cla_addsub #(.WIDTH(16), .BLOCK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .carryin(carryin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .carryout(carryout), .overflow(overflow), .zero(zero)
  );

  // Reference: {zero, overflow, carryout, Y} from plain integer arithmetic.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic s);
    logic [15:0] bp;
    logic        c;
    logic [16:0] full;
    int          r;
    logic        o;
    bp   = s ? ~b : b;
    c    = cin ^ s;
    full = {1'b0, a} + {1'b0, bp} + {16'd0, c};
    r    = int'($signed(a)) + int'($signed(bp)) + (c ? 1 : 0);
    o    = (r > 32767) || (r < -32768);
    return {(full[15:0] == 16'd0), o, full[16], full[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Scoreboard bookkeeping on the clock edge: record accepts, retire deliveries.
  always @(posedge clk) begin
    if (rst) begin
      drop_cnt += exp_q.size();
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        dlv_cnt++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(A, B, carryin, sub));
        acc_cnt++;
      end
    end
  end

  // Compare process: every valid output must match the oldest outstanding operation.
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL spurious_out: out_valid=1 with no pending op, Y=%0h", Y);
        end else begin
          check("result", 32'({zero, overflow, carryout, Y}), 32'(exp_q[0]));
        end
      end
    end
  end

  task automatic run_single(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic s, input logic [15:0] ey,
                            input logic ec, input logic eo, input logic ez);
    int lat;
    lat = -1;
    @(posedge clk); #1;
    in_valid = 1'b1; A = a; B = b; carryin = cin; sub = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 10 && lat < 0; i++) begin
      @(negedge clk);
      if (out_valid) lat = i;
    end
    // First valid negedge after accept edge N is the one following edge N+4.
    check({name, "_lat"}, 32'(lat), 32'd5);
    check({name, "_y"}, 32'(Y), 32'(ey));
    check({name, "_flags"}, 32'({carryout, overflow, zero}), 32'({ec, eo, ez}));
  endtask

  initial begin
    logic [15:0] vec;
    logic [15:0] held_y;
    logic        seen_v;
    logic        nonzero;
    int          n;
    int          a0;
    int          d0;
    int          cyc;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y", 32'(Y), 32'd0);
    check("rst_flags", 32'({carryout, overflow, zero}), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    run_single("add_zero", 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    run_single("add_3_2_c", 16'h0003, 16'h0002, 1'b1, 1'b0, 16'h0006, 1'b0, 1'b0, 1'b0);
    run_single("add_7_10", 16'h0007, 16'h000A, 1'b0, 1'b0, 16'h0011, 1'b0, 1'b0, 1'b0);
    run_single("add_ones", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_single("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_single("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_single("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_single("sub_zero", 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_single("sub_chain", 16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0, 1'b0);

    // Streaming: 8 back-to-back ops with alternating mode.
    vec = 16'h0000;
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          in_valid = 1'b1;
          A = 16'h2345 * 16'(i) + 16'h00FF;
          B = 16'h1357 * 16'(i);
          carryin = i[1];
          sub = i[0];
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 16; i++) begin
          @(negedge clk);
          vec[i] = out_valid;
        end
      end
    join
    check("stream_valid_pattern", 32'(vec), 32'h1FE0);

    // Backpressure: fill, stall for 5 cycles, then drain.
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      A = 16'hA5A5 ^ 16'(i * 4369);
      B = 16'h0F0F + 16'(i);
      carryin = i[1];
      sub = i[0];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    seen_v = 1'b0;
    for (int i = 0; i < 10 && !seen_v; i++) begin
      @(negedge clk);
      seen_v = out_valid;
    end
    check("bp_filled", 32'(seen_v), 32'd1);
    held_y = Y;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_y_stable", 32'(Y), 32'(held_y));
      check("bp_valid_held", 32'(out_valid), 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    d0 = dlv_cnt;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("bp_valid_cycles", 32'(n), 32'd4);
    check("bp_deliveries", 32'(dlv_cnt - d0), 32'd4);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-flight discards the three in-flight ops.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      A = 16'h1234 + 16'(i);
      B = 16'h4321;
      carryin = 1'b0;
      sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen_v = 1'b0;
    nonzero = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen_v = seen_v | out_valid;
      if ({Y, carryout, overflow, zero} != 19'd0) nonzero = 1'b1;
    end
    check("midrst_no_valid", 32'(seen_v), 32'd0);
    check("midrst_outputs_zero", 32'(nonzero), 32'd0);
    run_single("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

    // Random traffic with random bubbles and backpressure.
    a0 = acc_cnt;
    cyc = 0;
    while ((acc_cnt - a0) < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      A         = 16'($urandom);
      B         = 16'($urandom);
      carryin   = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("rand_accepts", 32'(acc_cnt - a0), 32'd10000);
    repeat (8) @(posedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("no_loss_dup", 32'(dlv_cnt + drop_cnt), 32'(acc_cnt));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
